mem_lsu: RTL and testbench

- Load/store unit for the MEM stage, directly upstream of the data RAM.
- Turns one memory request per cycle into the RAM's ce/we/sel/addr/data signals, using big-endian byte lanes.
- Aligns and extends load data for writeback, detects misaligned accesses, and keeps the LL/SC link bit.
- Stores go through a one-entry store buffer that drains when the RAM port is idle; loads get byte-wise forwarding from that buffer, so the unit never stalls.

---
 rtl/mem_lsu_pkg.sv | 16 +
 rtl/mem_lsu_store_buf.sv | 50 +++++
 rtl/mem_lsu.sv | 81 ++++++++
 tb/tb_mem_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: LSU op encodings, byte-lane masks and the lane-select helper.
package mem_lsu_pkg;
  typedef enum logic [3:0] {
    OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4,
    OP_SB = 4'd5, OP_SH = 4'd6, OP_SW = 4'd7, OP_LL = 4'd8, OP_SC = 4'd9
  } lsu_op_e;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_HI = 4'b1100;
  localparam logic [3:0] SEL_LO = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;
  // Big-endian: byte offset 0 lives in lane 3 (data[31:24]).
  function automatic logic [3:0] lane_mask(input lsu_op_e op, input logic [1:0] a);
    return (op inside {OP_LB, OP_LBU, OP_SB}) ? SEL_B3 >> a :
           (op inside {OP_LH, OP_LHU, OP_SH}) ? (a[1] ? SEL_LO : SEL_HI) : SEL_W;
  endfunction
endpackage

// File: rtl/mem_lsu_store_buf.sv
// mem_lsu_store_buf: one-entry store buffer with drain control and per-lane forward hits.
module mem_lsu_store_buf #(
  parameter int WA_W = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap_i,
  input  logic            hold_i,
  input  logic [WA_W-1:0] cap_addr_i,
  input  logic [3:0]      cap_sel_i,
  input  logic [31:0]     cap_data_i,
  input  logic [WA_W-1:0] look_addr_i,
  output logic            valid_o,
  output logic [WA_W-1:0] addr_o,
  output logic [3:0]      sel_o,
  output logic [31:0]     data_o,
  output logic            drain_o,
  output logic [3:0]      hit_o
);
  logic            valid_q, valid_d;
  logic [WA_W-1:0] addr_q, addr_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     data_q, data_d;
  assign drain_o = valid_q & ~hold_i;
  assign hit_o   = (valid_q && addr_q == look_addr_i) ? sel_q : 4'b0;
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign sel_o   = sel_q;
  assign data_o  = data_q;
  // A new store always lands here; the old entry drains on the port the same cycle.
  always_comb begin
    valid_d = cap_i | (valid_q & hold_i);
    addr_d  = cap_i ? cap_addr_i : addr_q;
    sel_d   = cap_i ? cap_sel_i : sel_q;
    data_d  = cap_i ? cap_data_i : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with big-endian lanes, store buffer forwarding and LL/SC.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter bit FLUSH_CLR_LL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic [31:0]       rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              sb_empty_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);
  localparam int WA_W = ADDR_W - 2;
  lsu_op_e         op;
  logic            is_ld, is_st, is_sc, is_b, is_h, mis, act, ok, ld, sc, st;
  logic [3:0]      sel, hit, sb_sel;
  logic [31:0]     wrep, merged, ld_val, sb_data;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [WA_W-1:0] wa, sb_addr;
  logic            sb_valid, drain, ll_q, ll_d;
  assign op    = lsu_op_e'(op_i);
  assign wa    = addr_i[ADDR_W-1:2];
  assign is_ld = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
  assign is_st = op inside {OP_SB, OP_SH, OP_SW};
  assign is_sc = op == OP_SC;
  assign is_b  = op inside {OP_LB, OP_LBU, OP_SB};
  assign is_h  = op inside {OP_LH, OP_LHU, OP_SH};
  assign mis   = is_h ? addr_i[0] : (is_b ? 1'b0 : |addr_i[1:0]);
  assign act   = req_i & (is_ld | is_st | is_sc);
  assign ok    = act & ~mis;
  assign ld    = ok & is_ld;
  assign sc    = ok & is_sc;
  assign st    = ok & (is_st | (is_sc & ll_q));
  assign adel_o = act & mis & is_ld;
  assign ades_o = act & mis & (is_st | is_sc);
  assign sel   = lane_mask(op, addr_i[1:0]);
  assign wrep  = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
  mem_lsu_store_buf #(.WA_W(WA_W)) u_sb (
    .clk(clk), .rst(rst), .cap_i(st), .hold_i(ld),
    .cap_addr_i(wa), .cap_sel_i(sel), .cap_data_i(wrep), .look_addr_i(wa),
    .valid_o(sb_valid), .addr_o(sb_addr), .sel_o(sb_sel), .data_o(sb_data),
    .drain_o(drain), .hit_o(hit)
  );
  for (genvar i = 0; i < 4; i++) begin : g_fwd
    assign merged[8*i +: 8] = hit[i] ? sb_data[8*i +: 8] : ram_rdata_i[8*i +: 8];
  end
  assign byte_v = merged[{~addr_i[1:0], 3'b000} +: 8];
  assign half_v = addr_i[1] ? merged[15:0] : merged[31:16];
  always_comb begin
    ld_val = (op == OP_LB)  ? {{24{byte_v[7]}}, byte_v} :
             (op == OP_LBU) ? {24'b0, byte_v} :
             (op == OP_LH)  ? {{16{half_v[15]}}, half_v} :
             (op == OP_LHU) ? {16'b0, half_v} : merged;
    ll_d   = (flush_i && FLUSH_CLR_LL) ? 1'b0 : (ld && op == OP_LL) ? 1'b1 : sc ? 1'b0 : ll_q;
  end
  assign rdata_o     = ld ? ld_val : {31'b0, sc & ll_q};
  assign sb_empty_o  = ~sb_valid;
  assign ram_ce_o    = ld | drain;
  assign ram_we_o    = drain;
  assign ram_sel_o   = ld ? sel : drain ? sb_sel : 4'b0;
  assign ram_addr_o  = ld ? {wa, 2'b00} : drain ? {sb_addr, 2'b00} : '0;
  assign ram_wdata_o = drain ? sb_data : 32'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ll_q <= 1'b0;
    else     ll_q <= ll_d;
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed plan plus randomized traffic checked against a byte-level model.
module tb_mem_lsu;
  localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7, LL = 8, SC = 9;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_i = 0, flush_i = 0;
  logic [3:0]  op_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, ram_rdata_i = 0;
  logic [31:0] rdata_o, ram_addr_o, ram_wdata_o;
  logic        adel_o, ades_o, sb_empty_o, ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;
  int checks = 0, errors = 0;

  mem_lsu #(.ADDR_W(32), .FLUSH_CLR_LL(1'b1)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o),
    .sb_empty_o(sb_empty_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );
  always #5 clk = ~clk;

  // Model state: buffered store as word address + per-byte-offset bytes, plus the link bit.
  bit          m_v, m_ll;
  logic [29:0] m_wa;
  bit          m_has[4];
  logic [7:0]  m_byte[4];
  // Expected outputs and pending effects of the current cycle.
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic        e_adel, e_ades, e_ce, e_we;
  logic [3:0]  e_sel;
  bit          x_load, x_store, x_ll, x_sc;
  bit          n_has[4];
  logic [7:0]  n_byte[4];
  // Captured DUT outputs of the last step, for literal checks.
  logic [31:0] c_rdata, c_addr, c_wdata;
  logic        c_adel, c_ades, c_ce, c_we, c_empty;
  logic [3:0]  c_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_eval(input bit r, input int op, input logic [31:0] a, input logic [31:0] w,
                            input logic [31:0] rd);
    int n, off;
    bit ld, st, sc, sgn, mis, ok;
    logic [31:0] v;
    logic [7:0] b;
    n = 4; ld = 0; st = 0; sc = 0; sgn = 0;
    case (op)
      LB: begin n = 1; ld = 1; sgn = 1; end
      LBU: begin n = 1; ld = 1; end
      LH: begin n = 2; ld = 1; sgn = 1; end
      LHU: begin n = 2; ld = 1; end
      LW, LL: ld = 1;
      SB: begin n = 1; st = 1; end
      SH: begin n = 2; st = 1; end
      SW: st = 1;
      default: sc = 1;
    endcase
    off = int'(a[1:0]);
    mis = r && (off % n != 0);
    ok = r && !mis;
    e_adel = mis && ld;
    e_ades = mis && (st || sc);
    x_load = ok && ld;
    x_sc = ok && sc;
    x_store = ok && (st || (sc && m_ll));
    x_ll = x_load && op == LL;
    for (int k = 0; k < 4; k++) begin
      n_has[k] = k >= off && k < off + n;
      n_byte[k] = 8'((w >> (8 * ((k - off) % n + (4 - n) % n * 0) )) & 0);
      n_byte[k] = 8'(w >> (8 * (n - 1 - (k % n))));
    end
    e_rdata = 0;
    if (x_load) begin
      v = 0;
      for (int k = off; k < off + n; k++) begin
        b = 8'(rd >> (8 * (3 - k)));
        if (m_v && m_wa == a[31:2] && m_has[k]) b = m_byte[k];
        v = (v << 8) | 32'(b);
      end
      if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      e_rdata = v;
    end else if (x_sc) e_rdata = 32'(m_ll);
    e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
    if (x_load) begin
      e_ce = 1; e_addr = {a[31:2], 2'b00};
      for (int k = off; k < off + n; k++) e_sel[3-k] = 1'b1;
    end else if (m_v) begin
      e_ce = 1; e_we = 1; e_addr = {m_wa, 2'b00};
      for (int k = 0; k < 4; k++) begin
        e_sel[3-k] = m_has[k];
        e_wdata[8*(3-k) +: 8] = m_byte[k];
      end
    end
  endtask

  task automatic model_update(input logic [31:0] a, input bit f);
    if (x_store) begin
      m_v = 1; m_wa = a[31:2];
      for (int k = 0; k < 4; k++) begin m_has[k] = n_has[k]; m_byte[k] = n_byte[k]; end
    end else if (m_v && !x_load) m_v = 0;
    if (f) m_ll = 0;
    else if (x_ll) m_ll = 1;
    else if (x_sc) m_ll = 0;
  endtask

  task automatic step(input bit r, input int op, input logic [31:0] a, input logic [31:0] w,
                      input bit f, input logic [31:0] rd);
    @(negedge clk);
    req_i = r; op_i = 4'(op); addr_i = a; wdata_i = w; flush_i = f; ram_rdata_i = rd;
    #1;
    model_eval(r, op, a, w, rd);
    c_rdata = rdata_o; c_addr = ram_addr_o; c_wdata = ram_wdata_o; c_adel = adel_o;
    c_ades = ades_o; c_ce = ram_ce_o; c_we = ram_we_o; c_empty = sb_empty_o; c_sel = ram_sel_o;
    chk("rdata", rdata_o, e_rdata);
    chk("adel", 32'(adel_o), 32'(e_adel));
    chk("ades", 32'(ades_o), 32'(e_ades));
    chk("sb_empty", 32'(sb_empty_o), 32'(!m_v));
    chk("ram_ce", 32'(ram_ce_o), 32'(e_ce));
    chk("ram_we", 32'(ram_we_o), 32'(e_we));
    chk("ram_sel", 32'(ram_sel_o), 32'(e_sel));
    chk("ram_addr", ram_addr_o, e_addr);
    chk("ram_wdata", ram_wdata_o, e_wdata);
    @(posedge clk);
    model_update(a, f);
  endtask

  task automatic idle(input bit f = 0);
    step(0, 0, 32'h0, 32'h0, f, 32'hDEAD_BEEF);
  endtask

  initial begin
    m_v = 0; m_ll = 0; m_wa = 0;
    for (int k = 0; k < 4; k++) begin m_has[k] = 0; m_byte[k] = 0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    chk("reset_empty", 32'(c_empty), 1);
    chk("reset_ce", 32'(c_ce), 0);
    step(1, SW, 32'h10, 32'hAABBCCDD, 0, 0);
    idle();
    chk("sw_drain_we", 32'(c_we), 1);
    chk("sw_drain_sel", 32'(c_sel), 32'hF);
    chk("sw_drain_addr", c_addr, 32'h10);
    chk("sw_drain_data", c_wdata, 32'hAABBCCDD);
    idle();
    chk("sw_empty_again", 32'(c_empty), 1);
    step(1, SB, 32'h13, 32'h000000EE, 0, 0);
    step(1, LW, 32'h10, 32'h0, 0, 32'h11223344);
    chk("lw_forward", c_rdata, 32'h112233EE);
    idle();
    chk("sb_held_after_load", 32'(c_empty), 0);
    chk("sb_drain_sel", 32'(c_sel), 32'h1);
    chk("sb_drain_data", c_wdata, 32'hEEEEEEEE);
    step(1, LH, 32'h12, 0, 0, 32'h12348001);
    chk("lh_sext", c_rdata, 32'hFFFF8001);
    step(1, LHU, 32'h12, 0, 0, 32'h12348001);
    chk("lhu_zext", c_rdata, 32'h00008001);
    step(1, LB, 32'h10, 0, 0, 32'h12348001);
    chk("lb", c_rdata, 32'h00000012);
    step(1, LW, 32'h11, 0, 0, 32'h12348001);
    chk("lw_mis_adel", 32'(c_adel), 1);
    chk("lw_mis_ce", 32'(c_ce), 0);
    step(1, SW, 32'h40, 32'h01020304, 0, 0);
    step(1, SH, 32'h13, 32'h5555, 0, 0);
    chk("sh_mis_ades", 32'(c_ades), 1);
    chk("sh_mis_old_entry", c_wdata, 32'h01020304);
    step(1, LL, 32'h20, 0, 0, 32'h0);
    step(1, SC, 32'h20, 32'h5, 0, 0);
    chk("sc_ok", c_rdata, 1);
    step(1, SC, 32'h20, 32'h6, 0, 0);
    chk("sc_fail", c_rdata, 0);
    chk("sc1_drain", c_wdata, 32'h5);
    idle();
    chk("sc2_no_store", 32'(c_ce), 0);
    step(1, LL, 32'h20, 0, 0, 32'h0);
    idle(1);
    step(1, SC, 32'h20, 32'h7, 0, 0);
    chk("sc_after_flush", c_rdata, 0);
    step(1, SW, 32'h0, 32'h1, 0, 0);
    step(1, SW, 32'h4, 32'h2, 0, 0);
    chk("b2b_first_drain", c_wdata, 32'h1);
    chk("b2b_first_addr", c_addr, 32'h0);
    idle();
    chk("b2b_second_drain", c_wdata, 32'h2);
    chk("b2b_second_addr", c_addr, 32'h4);
    for (int t = 0; t < 3000; t++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 9)), 32'($urandom_range(0, 63)),
           $urandom, $urandom_range(0, 15) == 0, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
